fir: RTL and testbench
======================

# fir

Fixed-coefficient, time-multiplexed FIR low-pass filter for 16-bit signed audio samples, used to denoise an audio stream. The block sits between the sample source and the sample sink in a single clock domain. It captures one input sample every `CLKS_PER_SAMPLE` clocks and runs a serial multiply-accumulate over `NTAPS` taps. It then presents one filtered, rounded 16-bit output per sample period.

## Interface
Clock is `clk`; reset is `sclr`, synchronous and active-high.

Parameters:
- `NTAPS`, default 32: number of taps; must be at least 2.
- `CLKS_PER_SAMPLE`, default 1134: input sample period in clocks. This is a 44.1 kHz sample rate at a 50 MHz clock. Must be at least `NTAPS`+3.
- `COEFFS`, default `fir_pkg::DEFAULT_COEFFS`: `NTAPS` signed 16-bit Q1.15 coefficients h[0..NTAPS-1].

Ports:
- `clk`, input, 1 bit: rising-edge clock.
- `sclr`, input, 1 bit: synchronous active-high reset.
- `din`, input, 16 bits: signed two's-complement sample; sampled only on the cycle `rfd`=1.
- `rfd`, output, 1 bit: ready-for-data; one-cycle pulse on the capture cycle.
- `rdy`, output, 1 bit: one-cycle pulse when `dout` updates.
- `dout`, output, 16 bits: signed filtered sample; held between `rdy` pulses.

## Operation
- **Period counter:** runs 0..`CLKS_PER_SAMPLE`-1 and then wraps to 0. `rfd`=1 exactly when the count is 0 and `sclr`=0.
- **Capture:** on an `rfd` cycle, `din` is written into an `NTAPS`-deep circular delay line. The write pointer advances modulo `NTAPS`, so the newest sample is x[n] and the oldest is x[n-NTAPS+1].
- **Compute:** the serial MAC is one tap per cycle. It forms y = Σ h[k]·x[n-k] for k=0..NTAPS-1.
  - Product: 16×16 signed gives a 32-bit Q2.30 product.
  - Accumulator: 32+ceil(log2 NTAPS) bits; no overflow is possible inside it.
- **Output conversion:** add 2^14 (round half up), arithmetically shift right by 15, then convert to 16 bits. With `FIR_SATURATE_EN` the conversion saturates; without it, it truncates (see Configuration).
- **Output register:** `dout` is registered and holds its value until the next `rdy` pulse.
- **Reset (`sclr`=1):**
  - delay line, accumulator, pointers and counters go to 0;
  - `dout` = 0, `rdy` = 0, `rfd` = 0.
  - A computation in progress is aborted, and no `rdy` is issued for it.
- **Reset release:** the first cycle with `sclr`=0 is an `rfd` cycle.

## Timing
- Let the capture (`rfd`) cycle be t0.
- MAC tap k is processed in cycle t0+1+k.
- There is one product pipeline register.
- `rdy` and the new `dout` appear at cycle t0+`NTAPS`+2.
- `rfd` and `rdy` never coincide, because `CLKS_PER_SAMPLE` ≥ `NTAPS`+3.
- `din` changes outside the `rfd` cycle have no effect.
- No backpressure: the sink must take `dout` within one sample period.

## Configuration
- **`FIR_SATURATE_EN` defined:**
  - results above 32767 clamp to 16'h7FFF;
  - results below -32768 clamp to 16'h8000.
- **Not defined:** the low 16 bits of the shifted result are output, which wraps on overflow.

## Structure
- **Package `fir_pkg`** holds:
  - `sample_t` (signed 16-bit) and `coeff_t` (signed 16-bit);
  - product and accumulator width constants;
  - `DEFAULT_COEFFS`: a 32-tap symmetric low-pass, cutoff about 4 kHz at fs 44.1 kHz, with DC gain Σh ≤ 32767.
- **Sub-module `fir_mac`:** registered multiply, accumulate, clear and round/saturate. The top level holds the counters, the delay line and the handshake.

## Test plan
- **Reset:** hold `sclr` for 3 cycles mid-stream. Required: `dout`=0, `rdy`=0, `rfd`=0 during reset; `rfd`=1 on the first cycle after release; the aborted computation produces no `rdy`.
- **Cadence:** free-run 5 periods. Required: `rfd` pulses exactly every 1134 clocks; each `rdy` comes exactly 34 clocks after its `rfd` (`NTAPS`=32).
- **Impulse:** `din`=16'h7FFF for one capture, then 0. Required: the successive `dout` values are (h[k]·32767+2^14)>>>15 for k=0..31, then 0.
- **DC:** `din`=16'h4000 held. Required: from the 32nd output onward, `dout`=(Σh·16384+2^14)>>>15, constant.
- **Overflow:** `COEFFS` all 16'h7FFF and `din`=16'h7FFF held. Required: with `FIR_SATURATE_EN`, `dout`=16'h7FFF; without it, `dout` equals the low 16 bits of the rounded, shifted sum.
- **Ignored input:** toggle `din` randomly between `rfd` pulses while the captured value stays 0. Required: `dout` stays 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types, widths and default coefficient set for the fir block.
package fir_pkg;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int PROD_W    = DATA_W + COEF_W;
  localparam int DEF_NTAPS = 32;
  localparam int DEF_ACC_W = PROD_W + $clog2(DEF_NTAPS);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coeff_t;

  // Accumulator width that cannot overflow when summing ntaps Q2.30 products.
  function automatic int acc_w(input int ntaps);
    return PROD_W + $clog2(ntaps);
  endfunction

  // 32-tap symmetric low-pass, cutoff near 4 kHz at 44.1 kHz, Q1.15.
  // Index 0 is the leftmost entry; DC gain sum(h) = 21270.
  localparam logic [0:DEF_NTAPS-1][COEF_W-1:0] DEFAULT_COEFFS = {
    16'hFFE2, 16'hFFD3, 16'hFFC4, 16'hFFC4, 16'hFFE2, 16'h0028, 16'h00A0, 16'h014A,
    16'h0226, 16'h0320, 16'h0424, 16'h0514, 16'h05DC, 16'h0668, 16'h06B8, 16'h06E0,
    16'h06E0, 16'h06B8, 16'h0668, 16'h05DC, 16'h0514, 16'h0424, 16'h0320, 16'h0226,
    16'h014A, 16'h00A0, 16'h0028, 16'hFFE2, 16'hFFC4, 16'hFFC4, 16'hFFD3, 16'hFFE2
  };

endpackage

// File: rtl/fir_mac.sv
// Serial multiply-accumulate for fir: registered product, accumulate with
// clear on the first tap, and round/convert of the final sum into dout.
// Optional macro FIR_SATURATE_EN: saturate the output instead of wrapping.
module fir_mac
  import fir_pkg::*;
#(
  parameter int NTAPS = 32
) (
  input  logic                     clk,
  input  logic                     sclr,
  input  logic                     tap_en,
  input  logic                     first,
  input  logic                     last,
  input  logic signed [COEF_W-1:0] coeff,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] dout,
  output logic                     rdy
);

  localparam int ACC_W    = acc_w(NTAPS);
  localparam int HALF_LSB = 1 << 14;
`ifdef FIR_SATURATE_EN
  localparam int HI_W     = ACC_W - DATA_W + 2;
`endif

  logic signed [PROD_W-1:0] prod_p0;
  logic                     vld_p0;
  logic                     first_p0;
  logic                     last_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W-1:0]  sum;

  // Round half up, drop 15 fraction bits, then narrow to the sample width.
  function automatic sample_t round_conv(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W:0] r;
    logic signed [ACC_W:0] s;
    r = $signed({x[ACC_W-1], x}) + $signed((ACC_W+1)'(HALF_LSB));
    s = r >>> 15;
`ifdef FIR_SATURATE_EN
    if (s[ACC_W:DATA_W-1] != {HI_W{s[DATA_W-1]}})
      return s[ACC_W] ? sample_t'({1'b1, {(DATA_W-1){1'b0}}})
                      : sample_t'({1'b0, {(DATA_W-1){1'b1}}});
`endif
    return s[DATA_W-1:0];
  endfunction

  // Running sum; the first tap restarts from zero instead of the old total.
  always_comb begin
    prod_ext = ACC_W'(prod_p0);
    base     = first_p0 ? '0 : acc_p1;
    sum      = base + prod_ext;
  end

  // Stage 0: tap control flags travel with the registered product.
  always_ff @(posedge clk) begin
    if (sclr) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
    end else begin
      vld_p0   <= tap_en;
      first_p0 <= first;
      last_p0  <= last;
    end
  end

  // Stage 0: registered 16x16 signed product (Q2.30).
  always_ff @(posedge clk) begin
    prod_p0 <= coeff * sample;
  end

  // Stage 1: accumulate; the last tap folds straight into the output register.
  always_ff @(posedge clk) begin
    if (sclr) begin
      acc_p1 <= '0;
      dout   <= '0;
      rdy    <= 1'b0;
    end else begin
      rdy <= vld_p0 & last_p0;
      if (vld_p0)
        acc_p1 <= sum;
      if (vld_p0 && last_p0)
        dout <= round_conv(sum);
    end
  end

endmodule

// File: rtl/fir.sv
// Time-multiplexed fixed-coefficient FIR low-pass. One sample is captured per
// CLKS_PER_SAMPLE clocks into a circular delay line, then fir_mac processes one
// tap per clock; rdy/dout follow the capture cycle by NTAPS+2 clocks.
// Optional macro FIR_SATURATE_EN (used in fir_mac): saturating output.
module fir
  import fir_pkg::*;
#(
  parameter int                                NTAPS           = 32,
  parameter int                                CLKS_PER_SAMPLE = 1134,
  parameter logic [0:NTAPS-1][COEF_W-1:0]      COEFFS          = DEFAULT_COEFFS
) (
  input  logic                     clk,
  input  logic                     sclr,
  input  logic signed [DATA_W-1:0] din,
  output logic                     rfd,
  output logic                     rdy,
  output logic signed [DATA_W-1:0] dout
);

  localparam int CW = $clog2(CLKS_PER_SAMPLE);
  localparam int PW = $clog2(NTAPS);

  logic [CW-1:0]            cnt;
  logic [PW-1:0]            wptr;
  logic [PW-1:0]            rptr;
  logic [PW-1:0]            tap;
  logic signed [DATA_W-1:0] line [NTAPS];
  logic                     tap_en;
  logic                     first;
  logic                     last;
  logic signed [COEF_W-1:0] coeff;
  logic signed [DATA_W-1:0] sample;

  // Capture happens at count 0; taps occupy counts 1..NTAPS.
  assign rfd    = (cnt == '0) && !sclr;
  assign tap_en = (cnt >= CW'(1)) && (cnt <= CW'(NTAPS));
  assign first  = (cnt == CW'(1));
  assign last   = (cnt == CW'(NTAPS));
  assign coeff  = coeff_t'(COEFFS[tap]);
  assign sample = line[rptr];

  // Sample-period counter, wrapping at CLKS_PER_SAMPLE.
  always_ff @(posedge clk) begin
    if (sclr)
      cnt <= '0;
    else if (cnt == CW'(CLKS_PER_SAMPLE - 1))
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  // Delay line write on capture; read pointer walks from newest to oldest.
  always_ff @(posedge clk) begin
    if (sclr) begin
      for (int i = 0; i < NTAPS; i++)
        line[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      tap  <= '0;
    end else if (rfd) begin
      line[wptr] <= din;
      wptr       <= (wptr == PW'(NTAPS - 1)) ? '0 : wptr + PW'(1);
      rptr       <= wptr;
      tap        <= '0;
    end else if (tap_en) begin
      rptr <= (rptr == '0) ? PW'(NTAPS - 1) : rptr - PW'(1);
      tap  <= tap + PW'(1);
    end
  end

  fir_mac #(
    .NTAPS(NTAPS)
  ) u_mac (
    .clk    (clk),
    .sclr   (sclr),
    .tap_en (tap_en),
    .first  (first),
    .last   (last),
    .coeff  (coeff),
    .sample (sample),
    .dout   (dout),
    .rdy    (rdy)
  );

endmodule

// File: tb/tb_fir.sv
// Bench for fir: three instances (default cadence, fast-period default taps,
// fast-period all-0x7FFF taps) checked against a direct-form reference model.
module tb_fir;

  localparam int NT      = 32;
  localparam int FAST    = 40;
  localparam int LATENCY = NT + 2;

  logic                clk = 1'b0;
  logic                sclr = 1'b1;
  logic signed [15:0]  din  [3];
  logic                rfd  [3];
  logic                rdy  [3];
  logic signed [15:0]  dout [3];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int rfd_seen [3];

  logic signed [15:0] q [3][$];
  int                 hist [3][NT];

  always #5 clk = ~clk;

  // Free-running cycle index used for cadence measurements.
  always @(posedge clk) cyc <= cyc + 1;

  fir u_a (
    .clk(clk), .sclr(sclr), .din(din[0]), .rfd(rfd[0]), .rdy(rdy[0]), .dout(dout[0])
  );

  fir #(.NTAPS(NT), .CLKS_PER_SAMPLE(FAST)) u_b (
    .clk(clk), .sclr(sclr), .din(din[1]), .rfd(rfd[1]), .rdy(rdy[1]), .dout(dout[1])
  );

  fir #(.NTAPS(NT), .CLKS_PER_SAMPLE(FAST), .COEFFS({32{16'h7FFF}})) u_c (
    .clk(clk), .sclr(sclr), .din(din[2]), .rfd(rfd[2]), .rdy(rdy[2]), .dout(dout[2])
  );

  function automatic int coef(input int g, input int k);
    logic [15:0] c;
    if (g == 2) return 32767;
    c = fir_pkg::DEFAULT_COEFFS[k];
    return int'($signed(c));
  endfunction

  function automatic logic signed [15:0] conv(input longint acc);
    longint s;
    logic [63:0] b;
    s = (acc + 64'sd16384) >>> 15;
`ifdef FIR_SATURATE_EN
    if (s > 32767)  return 16'sh7FFF;
    if (s < -32768) return 16'sh8000;
`endif
    b = s;
    return b[15:0];
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: push the model result at each capture, pop and compare at rdy.
  task automatic monitor();
    int     last_rfd [3];
    bit     have_last [3];
    longint acc;
    int     per;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        per = (g == 0) ? 1134 : FAST;
        if (sclr) begin
          q[g].delete();
          for (int k = 0; k < NT; k++) hist[g][k] = 0;
          have_last[g] = 1'b0;
        end else begin
          if (rdy[g]) begin
            check($sformatf("rdy_latency%0d", g),
                  have_last[g] ? cyc - last_rfd[g] : -1, LATENCY);
            check($sformatf("rdy_expected%0d", g), q[g].size() != 0, 1);
            if (q[g].size() != 0)
              check($sformatf("dout%0d", g), dout[g], q[g].pop_front());
          end
          if (rfd[g]) begin
            if (have_last[g])
              check($sformatf("rfd_period%0d", g), cyc - last_rfd[g], per);
            have_last[g] = 1'b1;
            last_rfd[g]  = cyc;
            rfd_seen[g]++;
            for (int k = NT - 1; k > 0; k--) hist[g][k] = hist[g][k-1];
            hist[g][0] = int'(din[g]);
            acc = 0;
            for (int k = 0; k < NT; k++)
              acc += longint'(coef(g, k)) * longint'(hist[g][k]);
            q[g].push_back(conv(acc));
          end
        end
      end
    end
  endtask

  // Wait (bounded) for instance g to show rfd, then step past the capture edge.
  task automatic wait_rfd(input int g);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      got = rfd[g];
    end
    check($sformatf("rfd_timeout%0d", g), got, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int g, input logic signed [15:0] v);
    din[g] = v;
    wait_rfd(g);
  endtask

  initial begin
    longint dc_sum;
    int     rdy_hits;
    din[0] = 16'sh1234;
    din[1] = 16'sh0000;
    din[2] = 16'sh7FFF;
    for (int g = 0; g < 3; g++) rfd_seen[g] = 0;
    fork
      monitor();
    join_none

    // Power-on reset: outputs quiet, first released cycle captures.
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_dout", dout[0], 0);
      check("reset_rdy", rdy[0], 0);
      check("reset_rfd", rfd[0], 0);
    end
    sclr = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) check($sformatf("release_rfd%0d", g), rfd[g], 1);
    @(posedge clk);
    #1;

    // Impulse on the fast instance: full-scale once, then zeros.
    capture(1, 16'sh7FFF);
    repeat (NT + 1) capture(1, 16'sh0000);

    // DC input held; the settled output is the DC gain times the input.
    repeat (NT + 2) capture(1, 16'sh4000);
    repeat (LATENCY + 2) @(posedge clk);
    #1;
    dc_sum = 0;
    for (int k = 0; k < NT; k++) dc_sum += longint'(coef(1, k));
    check("dc_settled", dout[1], conv(dc_sum * 16384));

    // Overflow instance has seen full-scale input with full-scale taps throughout.
    check("overflow", dout[2], conv(longint'(NT) * 32767 * 32767));

    // Let the default-rate instance run at least five full periods.
    for (int i = 0; i < 8000 && rfd_seen[0] < 6; i++) @(negedge clk);
    check("cadence_periods", rfd_seen[0] >= 6, 1);

    // Mid-computation reset on the default instance.
    wait_rfd(0);
    repeat (9) @(posedge clk);
    #1;
    sclr = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("midreset_dout", dout[0], 0);
      check("midreset_rdy", rdy[0], 0);
      check("midreset_rfd", rfd[0], 0);
    end
    din[1] = 16'sh0000;
    sclr   = 1'b0;
    #1;
    check("midrelease_rfd", rfd[0], 1);
    rdy_hits = 0;
    repeat (LATENCY - 1) begin
      @(posedge clk);
      #1;
      if (rdy[0]) rdy_hits++;
    end
    check("aborted_no_rdy", rdy_hits, 0);
    @(posedge clk);
    #1;
    check("post_reset_rdy", rdy[0], 1);

    // Random din between captures must never reach the filter.
    repeat (5) begin
      wait_rfd(1);
      repeat (FAST - 3) begin
        din[1] = 16'($urandom);
        @(posedge clk);
        #1;
      end
      din[1] = 16'sh0000;
    end
    repeat (LATENCY + 2) @(posedge clk);
    #1;
    check("ignored_din", dout[1], 0);

    repeat (FAST) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
